// File: rtl/test_deserialize_pkg.sv
// test_deserialize_pkg: shared definitions for the serial-to-parallel reader.
//   - default geometry (XLEN_DEF / SW_DEF / BN_DEF)
//   - cnt_width(): beat counter width for a given beats-per-word (minimum 1)
//   - cnt_t: beat counter type for the default geometry
//   - bitrev(): reverse the low 'width' bits of a value; also used by the
//     combinational bit-reverse block. Widths up to BITREV_W are supported.
package test_deserialize_pkg;

    localparam int unsigned BITREV_W = 64;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned SW_DEF   = 8;
    localparam int unsigned BN_DEF   = XLEN_DEF / SW_DEF;

    function automatic int unsigned cnt_width(input int unsigned bn);
        return (bn > 1) ? $clog2(bn) : 1;
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(BN_DEF);

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] value,
                                                   input int unsigned          width);
        logic [BITREV_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_W; i++) begin
            if (i < width) begin
                r[i] = value[width-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/test_deserialize_shift.sv
// test_deserialize_shift: collection register, beat counter and bit-order latch.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   beat_en      a beat is accepted this cycle
//   beat_sof     the accepted beat is forced to be beat 0
//   cfg_msb      bit order, used only on beat 0 (1 = MSB-first)
//   beat_dat     beat data, beat_dat[SW-1] is the earliest stream bit
//   cnt          current beat counter (index of the next non-sof beat)
//   done         pulses with the acceptance of beat BN-1
//   word         completed word, valid while done is high
module test_deserialize_shift
    import test_deserialize_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned SW   = SW_DEF,
    localparam int unsigned BN  = XLEN / SW,
    localparam int unsigned CntW = cnt_width(BN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            beat_en,
    input  logic            beat_sof,
    input  logic            cfg_msb,
    input  logic [SW-1:0]   beat_dat,
    output logic [CntW-1:0] cnt,
    output logic            done,
    output logic [XLEN-1:0] word
);

    logic [XLEN-1:0]     sr_q, sr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                order_q, order_d;
    logic [CntW-1:0]     idx;
    logic                first, last, order;
    logic [BITREV_W-1:0] dat_rev;
    int unsigned         pos;

    always_comb begin
        // A sof beat restarts the word regardless of the running count.
        idx     = beat_sof ? '0 : cnt_q;
        first   = (idx == '0);
        last    = (idx == CntW'(BN - 1));
        order   = first ? cfg_msb : order_q;
        dat_rev = bitrev(BITREV_W'(beat_dat), SW);

        sr_d    = sr_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        pos     = 0;

        if (beat_en) begin
            if (first) begin
                sr_d    = '0;
                order_d = cfg_msb;
            end
            // MSB-first fills from the top down; LSB-first fills from bit 0 up
            // with each beat reversed so its earliest bit lands lowest.
            if (order) begin
                pos = (BN - 1 - int'(idx)) * SW;
                sr_d[pos +: SW] = beat_dat;
            end else begin
                pos = int'(idx) * SW;
                sr_d[pos +: SW] = dat_rev[SW-1:0];
            end
            cnt_d = last ? '0 : idx + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            order_q <= 1'b1;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = beat_en & last;
    assign word = sr_d;

endmodule

// File: rtl/test_deserialize.sv
// test_deserialize: assembles SW-bit beats into XLEN-bit words, MSB- or LSB-first.
// Optional build macro: TEST_DESERIALIZE_PARITY_EN adds per-beat even parity
// checking (sti_par in, dto_err out).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   cfg_msb      bit order, sampled on beat 0 (1 = MSB-first, 0 = LSB-first)
//   sti_vld/rdy  input beat handshake; sti_sof marks beat 0; sti_dat beat data
//   sti_par      (parity build) even parity bit for sti_dat
//   dto_vld/rdy  output word handshake; dto_dat assembled word
//   dto_err      (parity build) some beat of the word had bad parity
module test_deserialize
    import test_deserialize_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned SW   = SW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_msb,
    input  logic            sti_vld,
    output logic            sti_rdy,
    input  logic            sti_sof,
    input  logic [SW-1:0]   sti_dat,
`ifdef TEST_DESERIALIZE_PARITY_EN
    input  logic            sti_par,
    output logic            dto_err,
`endif
    output logic            dto_vld,
    input  logic            dto_rdy,
    output logic [XLEN-1:0] dto_dat
);

    localparam int unsigned BN   = XLEN / SW;
    localparam int unsigned CntW = cnt_width(BN);

    if ((SW == 0) || (SW > XLEN) || ((XLEN % SW) != 0)) begin : g_bad_geometry
        $error("SW must divide XLEN and satisfy 1 <= SW <= XLEN");
    end

    logic [CntW-1:0] cnt;
    logic            beat_acc;
    logic            done;
    logic [XLEN-1:0] word;
    logic            vld_q, vld_d;
    logic [XLEN-1:0] dat_q, dat_d;

    // Only the last beat needs the output slot, so earlier beats keep flowing
    // while a word is held.
    assign sti_rdy  = !((cnt == CntW'(BN - 1)) && vld_q && !dto_rdy);
    assign beat_acc = sti_vld & sti_rdy;

    test_deserialize_shift #(
        .XLEN (XLEN),
        .SW   (SW)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat_en  (beat_acc),
        .beat_sof (sti_sof),
        .cfg_msb  (cfg_msb),
        .beat_dat (sti_dat),
        .cnt      (cnt),
        .done     (done),
        .word     (word)
    );

    // A completing word takes priority over a read, so read + complete in the
    // same cycle keeps dto_vld high with the new word.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (done) begin
            vld_d = 1'b1;
            dat_d = word;
        end else if (vld_q && dto_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign dto_vld = vld_q;
    assign dto_dat = dat_q;

`ifdef TEST_DESERIALIZE_PARITY_EN
    logic first;
    logic beat_err;
    logic acc_q, acc_d;
    logic err_q, err_d;

    assign first    = sti_sof | (cnt == '0);
    assign beat_err = (^sti_dat) ^ sti_par;

    always_comb begin
        acc_d = acc_q;
        err_d = err_q;
        if (beat_acc) begin
            acc_d = (first ? 1'b0 : acc_q) | beat_err;
        end
        if (done) begin
            err_d = acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    assign dto_err = err_q;
`endif

endmodule

// File: tb/tb_test_deserialize.sv
// Bench for test_deserialize (XLEN=32, SW=8): directed scenarios plus a
// randomized run checked against a bit-stream reference model.
module tb_test_deserialize;

    localparam int XLEN = 32;
    localparam int SW   = 8;
    localparam int BN   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_msb;
    logic            sti_vld;
    logic            sti_rdy;
    logic            sti_sof;
    logic [SW-1:0]   sti_dat;
    logic            dto_vld;
    logic            dto_rdy;
    logic [XLEN-1:0] dto_dat;
`ifdef TEST_DESERIALIZE_PARITY_EN
    logic            sti_par;
    logic            dto_err;
    logic            par_flip = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    test_deserialize #(
        .XLEN (XLEN),
        .SW   (SW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_msb (cfg_msb),
        .sti_vld (sti_vld),
        .sti_rdy (sti_rdy),
        .sti_sof (sti_sof),
        .sti_dat (sti_dat),
`ifdef TEST_DESERIALIZE_PARITY_EN
        .sti_par (sti_par),
        .dto_err (dto_err),
`endif
        .dto_vld (dto_vld),
        .dto_rdy (dto_rdy),
        .dto_dat (dto_dat)
    );

    // Reference: stream bit k (b0 = beat0[SW-1]) goes to bit XLEN-1-k (MSB-first)
    // or bit k (LSB-first).
    function automatic logic [XLEN-1:0] ref_word(input logic [SW-1:0] b [BN], input logic msb);
        logic            bits [XLEN];
        logic [XLEN-1:0] w;
        for (int j = 0; j < BN; j++)
            for (int i = 0; i < SW; i++)
                bits[j*SW+i] = b[j][SW-1-i];
        w = '0;
        for (int k = 0; k < XLEN; k++) begin
            if (msb) w[XLEN-1-k] = bits[k];
            else     w[k] = bits[k];
        end
        return w;
    endfunction

    // Drive one beat and wait (bounded) until it is accepted; returns at posedge+1.
    task automatic send_beat(input logic [SW-1:0] d, input logic sof, input logic msb);
        int n = 0;
        sti_vld = 1'b1;
        sti_dat = d;
        sti_sof = sof;
        cfg_msb = msb;
`ifdef TEST_DESERIALIZE_PARITY_EN
        sti_par = (^d) ^ par_flip;
`endif
        forever begin
            #1;
            if (sti_rdy) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL beat_accept_timeout: sti_rdy stayed 0, required 1 within 20 cycles");
                break;
            end
        end
        sti_vld = 1'b0;
        sti_sof = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sti_vld = 0; sti_sof = 0; sti_dat = 0; cfg_msb = 1; dto_rdy = 1;
`ifdef TEST_DESERIALIZE_PARITY_EN
        sti_par = 0;
`endif
        #3;
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", dto_vld); end
        checks++; if (dto_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", dto_dat); end
        checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", sti_rdy); end
`ifdef TEST_DESERIALIZE_PARITY_EN
        checks++; if (dto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", dto_err); end
`endif
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_msb();
        dto_rdy = 1;
        send_beat(8'h12, 1, 1);
        send_beat(8'h34, 0, 1);
        send_beat(8'h56, 0, 1);
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL msb_early_vld: got %b want 0", dto_vld); end
        send_beat(8'h78, 0, 1);
        checks++; if (dto_vld !== 1'b1) begin errors++; $display("FAIL msb_latency: got vld=%b want 1", dto_vld); end
        checks++; if (dto_dat !== 32'h12345678) begin errors++; $display("FAIL msb_word: got %h want 12345678", dto_dat); end
        @(posedge clk); #1;
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL msb_consumed: got vld=%b want 0", dto_vld); end
    endtask

    task automatic test_lsb();
        dto_rdy = 1;
        send_beat(8'h12, 1, 0);
        send_beat(8'h34, 0, 1);   // order changes after beat 0 must be ignored
        send_beat(8'h56, 0, 1);
        send_beat(8'h78, 0, 1);
        checks++; if (dto_vld !== 1'b1) begin errors++; $display("FAIL lsb_vld: got %b want 1", dto_vld); end
        checks++; if (dto_dat !== 32'h1E6A2C48) begin errors++; $display("FAIL lsb_word: got %h want 1e6a2c48", dto_dat); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [SW-1:0]   w1 [BN];
        logic [SW-1:0]   w2 [BN];
        logic            msb;
        logic [XLEN-1:0] e1, e2;
        msb = 1'($urandom);
        for (int i = 0; i < BN; i++) begin
            w1[i] = 8'($urandom);
            w2[i] = 8'($urandom);
        end
        e1 = ref_word(w1, msb);
        e2 = ref_word(w2, msb);
        dto_rdy = 0;
        for (int i = 0; i < BN; i++) send_beat(w1[i], i == 0, msb);
        for (int i = 0; i < BN - 1; i++) send_beat(w2[i], i == 0, msb);
        sti_vld = 1; sti_dat = w2[BN-1]; sti_sof = 0;
`ifdef TEST_DESERIALIZE_PARITY_EN
        sti_par = ^w2[BN-1];
`endif
        #1;
        checks++; if (sti_rdy !== 1'b0) begin errors++; $display("FAIL bp_stall: got rdy=%b want 0", sti_rdy); end
        @(posedge clk); #1;
        checks++; if (dto_dat !== e1) begin errors++; $display("FAIL bp_hold: got %h want %h", dto_dat, e1); end
        dto_rdy = 1;
        #1;
        checks++; if (sti_rdy !== 1'b1) begin errors++; $display("FAIL bp_release: got rdy=%b want 1", sti_rdy); end
        @(posedge clk); #1;
        sti_vld = 0;
        checks++; if (dto_vld !== 1'b1) begin errors++; $display("FAIL bp_no_bubble: got vld=%b want 1", dto_vld); end
        checks++; if (dto_dat !== e2) begin errors++; $display("FAIL bp_word2: got %h want %h", dto_dat, e2); end
        @(posedge clk); #1;
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL bp_drain: got vld=%b want 0", dto_vld); end
    endtask

    task automatic test_resync();
        dto_rdy = 1;
        send_beat(8'hAA, 1, 1);
        send_beat(8'hBB, 0, 1);
        send_beat(8'h01, 1, 1);
        send_beat(8'h02, 0, 1);
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL resync_partial_a: got vld=%b want 0", dto_vld); end
        send_beat(8'h03, 0, 1);
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL resync_partial_b: got vld=%b want 0", dto_vld); end
        send_beat(8'h04, 0, 1);
        checks++; if (dto_dat !== 32'h01020304 || dto_vld !== 1'b1)
            begin errors++; $display("FAIL resync_word: got vld=%b %h want 1 01020304", dto_vld, dto_dat); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        dto_rdy = 0;
        send_beat(8'hC3, 1, 1);
        send_beat(8'h5A, 0, 1);
        send_beat(8'h0F, 0, 1);
        send_beat(8'hF0, 0, 1);
        checks++; if (dto_vld !== 1'b1) begin errors++; $display("FAIL ar_held: got vld=%b want 1", dto_vld); end
        send_beat(8'h99, 1, 0);
        send_beat(8'h66, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dto_vld !== 1'b0) begin errors++; $display("FAIL ar_vld: got %b want 0", dto_vld); end
        checks++; if (dto_dat !== '0) begin errors++; $display("FAIL ar_dat: got %h want 0", dto_dat); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        dto_rdy = 1;
        send_beat(8'h11, 0, 1);
        send_beat(8'h22, 0, 1);
        send_beat(8'h33, 0, 1);
        send_beat(8'h44, 0, 1);
        checks++; if (dto_dat !== 32'h11223344 || dto_vld !== 1'b1)
            begin errors++; $display("FAIL ar_clean_word: got vld=%b %h want 1 11223344", dto_vld, dto_dat); end
        @(posedge clk); #1;
    endtask

`ifdef TEST_DESERIALIZE_PARITY_EN
    task automatic test_parity();
        dto_rdy = 1;
        send_beat(8'h12, 1, 1);
        par_flip = 1'b1;
        send_beat(8'h34, 0, 1);
        par_flip = 1'b0;
        send_beat(8'h56, 0, 1);
        send_beat(8'h78, 0, 1);
        checks++; if (dto_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b want 1", dto_err); end
        send_beat(8'h9A, 1, 1);
        send_beat(8'hBC, 0, 1);
        send_beat(8'hDE, 0, 1);
        send_beat(8'hF1, 0, 1);
        checks++; if (dto_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b want 0", dto_err); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random();
        logic [XLEN-1:0] wq [$];
        logic            eq [$];
        logic [SW-1:0]   beats [BN];
        int              part_n = 0;
        logic            order = 1'b1;
        logic            perr = 1'b0;
        logic            exp_rdy, in_x, out_x, bad;
        pulse_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            sti_vld = ($urandom % 4) != 0;
            sti_sof = ($urandom % 8) == 0;
            cfg_msb = 1'($urandom);
            sti_dat = 8'($urandom);
            dto_rdy = ($urandom % 3) != 0;
            bad     = ($urandom % 16) == 0;
`ifdef TEST_DESERIALIZE_PARITY_EN
            sti_par = (^sti_dat) ^ bad;
`endif
            #1;
            checks++;
            if (dto_vld !== (wq.size() != 0)) begin
                errors++; $display("FAIL rnd_vld cyc=%0d: got %b want %b", cyc, dto_vld, wq.size() != 0);
            end
            exp_rdy = !(part_n == BN - 1 && wq.size() != 0 && !dto_rdy);
            checks++;
            if (sti_rdy !== exp_rdy) begin
                errors++; $display("FAIL rnd_rdy cyc=%0d: got %b want %b", cyc, sti_rdy, exp_rdy);
            end
            out_x = (wq.size() != 0) && dto_rdy;
            in_x  = sti_vld && exp_rdy;
            if (out_x) begin
                checks++;
                if (dto_dat !== wq[0]) begin
                    errors++; $display("FAIL rnd_word cyc=%0d: got %h want %h", cyc, dto_dat, wq[0]);
                end
`ifdef TEST_DESERIALIZE_PARITY_EN
                checks++;
                if (dto_err !== eq[0]) begin
                    errors++; $display("FAIL rnd_err cyc=%0d: got %b want %b", cyc, dto_err, eq[0]);
                end
`endif
                void'(wq.pop_front());
                void'(eq.pop_front());
            end
            if (in_x) begin
                if (sti_sof) part_n = 0;
                if (part_n == 0) begin
                    order = cfg_msb;
                    perr  = 1'b0;
                end
                beats[part_n] = sti_dat;
                perr = perr | bad;
                part_n++;
                if (part_n == BN) begin
                    wq.push_back(ref_word(beats, order));
                    eq.push_back(perr);
                    part_n = 0;
                end
            end
            @(posedge clk); #1;
        end
        sti_vld = 0;
        sti_sof = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_backpressure();
        test_resync();
        test_async_reset();
`ifdef TEST_DESERIALIZE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/test_deserialize.md
Name: test_deserialize

Overview:
- Serial-to-parallel reader for a bit-ordered stream.
- Accepts SW-bit beats on a valid/ready input and assembles XLEN-bit words, MSB-first or LSB-first.
- Presents each word on a valid/ready output.
- Complements the combinational bit-reverse block: an LSB-first stream yields the bit reversal of the same stream read MSB-first.

Parameters:
- XLEN, 32, output word width in bits.
- SW, 8, beat width in bits; must divide XLEN exactly; 1 <= SW <= XLEN.
- BN, XLEN/SW (localparam), beats per word.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cfg_msb  input  1  bit order: 1 = MSB-first, 0 = LSB-first; sampled on the first beat of each word.
- sti_vld  input  1  input beat valid.
- sti_rdy  output  1  input beat ready.
- sti_sof  input  1  start of frame; qualifies the beat as beat 0.
- sti_dat  input  SW  input beat; sti_dat[SW-1] is the earliest bit on the stream.
- dto_vld  output  1  output word valid.
- dto_rdy  input  1  output word ready.
- dto_dat  output  XLEN  assembled word.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - sti_rdy=1 (combinational; see stall rule), dto_vld=0, dto_dat=0.
  - Beat counter=0, shift register=0, latched order=1.
- Handshakes:
  - Input transfer when sti_vld & sti_rdy.
  - Output transfer when dto_vld & dto_rdy.
  - dto_dat is stable while dto_vld & !dto_rdy.
- Datapath: a collection register (shift register plus beat counter 0..BN-1) feeds a one-entry output register.
- Bit mapping: stream bits b0,b1,... with b0 = first beat's sti_dat[SW-1].
  - MSB-first: b_k -> dto_dat[XLEN-1-k].
  - LSB-first: b_k -> dto_dat[k].
  - For an identical stream, LSB result == bit-reverse(MSB result).
- Order latching: cfg_msb is latched when beat 0 is accepted. Changes mid-word are ignored until the next beat 0.
- sti_sof:
  - An accepted beat with sti_sof=1 is beat 0 and silently discards any partial word.
  - sti_sof=0 beats continue the count.
  - Beats after reset without sof are still counted from 0.
- Word completion: on acceptance of beat BN-1, the word moves to the output register and dto_vld=1 on the next cycle. Latency is one cycle from the last beat to dto_vld. The counter wraps to 0.
- Stall rule: sti_rdy = !(cnt==BN-1 & dto_vld & !dto_rdy). Beats 0..BN-2 are accepted while the output is held.
- Simultaneous events: output handshake and last-beat acceptance in the same cycle means the new word replaces the old one with no bubble; dto_vld stays 1.
- SW==XLEN: BN=1, every accepted beat is a word, and the counter stays 0.
- Reset mid-word or mid-hold: partial and held words are lost and the block returns to reset values.

Optional Feature:
- Macro: TEST_DESERIALIZE_PARITY_EN.
- Enabled:
  - Adds input sti_par (1 bit per beat, even parity over sti_dat).
  - Adds output dto_err (1 bit), valid with dto_vld.
  - dto_err = OR over the word's beats of (^sti_dat ^ sti_par).
  - Error accumulation clears on beat 0; reset value 0.
- Disabled: neither port exists and no parity logic is present.
- Data behaviour is identical in both builds.

Decomposition:
- Package test_deserialize_pkg:
  - Function bitrev(value, width), shared with the bit-reverse block.
  - Typedef for the beat counter width $clog2(BN) (minimum 1).
- Sub-module test_deserialize_shift: collection register, beat counter and order latch. It emits the completed word and a done pulse.
- The top holds the output register, handshakes and the optional parity.

Test Plan:
- MSB-first, XLEN=32/SW=8: sof beats 0x12,0x34,0x56,0x78 with dto_rdy=1 -> dto_dat=0x12345678, dto_vld exactly one cycle after the 4th beat.
- LSB-first, same stream -> dto_dat=0x1E6A2C48; cfg_msb toggled after beat 0 has no effect.
- Backpressure: dto_rdy=0 while two words stream -> beats 0..2 of word 2 accepted, sti_rdy=0 at beat 3. On dto_rdy=1, word1 is read, then word2 appears the next cycle with no lost beat.
- Resync: beats 0xAA,0xBB, then a sof beat followed by 0x01,0x02,0x03,0x04 -> single word 0x01020304; the partial is discarded.
- Reset: rst_n low asynchronously after 2 beats and while dto_vld=1 -> dto_vld=0 and dto_dat=0 immediately; the next 4 beats give a clean word.
- Parity (macro on): beat 0x34 with sti_par=0 -> dto_err=1 for that word only. Next correct word -> dto_err=0.
